key_debounce: RTL and testbench
===============================

# key_debounce

Debounces one raw active-low push-button on the fabric clock and emits a clean debounced level plus a single-cycle press tick. Sits directly upstream of `bcd_counter`: `tick` drives the counter's step input, so the counter advances exactly once per physical press instead of running off the bouncing KEY line. One instance is used per KEY.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable samples required to accept a change (20 ms at 50 MHz); legal range is ≥ 2.
- `REPEAT_DELAY`, default 25000000: cycles a key must be held before the first auto-repeat tick. Only used with `KEY_REPEAT_EN`.
- `REPEAT_PERIOD`, default 5000000: cycles between successive auto-repeat ticks. Only used with `KEY_REPEAT_EN`.
- `ck` input 1: single fabric clock; all logic is on the rising edge.
- `rs` input 1: synchronous reset, active-high.
- `key_n` input 1: raw button, asynchronous to `ck`; 0 means pressed.
- `level` output 1: debounced state; 1 means pressed.
- `tick` output 1: one-cycle pulse per accepted press (and per repeat, when enabled).

## Operation
- `key_n` passes through a 2-FF synchronizer. The synchronizer flops reset to 1 (released). The synchronized signal is `s` = NOT of the second flop.
- The state machine has four states: IDLE, PRESS_WAIT, HELD, REL_WAIT. A single counter `cnt` of width $clog2(DEBOUNCE_CYCLES) is shared between the wait states.
- **IDLE:** `s`=1 → PRESS_WAIT with `cnt`=1. Otherwise stay.
- **PRESS_WAIT:**
  - `s`=0 → IDLE (treated as bounce, no output).
  - `s`=1 and `cnt`==DEBOUNCE_CYCLES-1 → HELD; set `level`=1; `tick`=1 for that one cycle.
  - Otherwise `cnt`++.
- **HELD:** `s`=0 → REL_WAIT with `cnt`=1. Otherwise stay.
- **REL_WAIT:**
  - `s`=1 → HELD, with no tick (release bounce).
  - `s`=0 and `cnt`==DEBOUNCE_CYCLES-1 → IDLE; set `level`=0.
  - Otherwise `cnt`++.
- `tick` and `level` are registered outputs.
- `tick` is never high on two consecutive cycles.
- `tick` is never high while the state is REL_WAIT or IDLE.
- Counters saturate by construction: they are cleared on every state entry and never wrap.

## Timing
- Reset values: state=IDLE, `cnt`=0, `level`=0, `tick`=0, synchronizer flops=1. Applies whenever `rs` is sampled high.
- Press latency: let edge 1 be the first edge that samples the new `key_n` value. A clean press gives `tick`=1 and `level`=1 in the cycle after edge DEBOUNCE_CYCLES+2.
- Release latency: a clean release gives `level`=0 after edge DEBOUNCE_CYCLES+2, counted the same way.
- Any glitch shorter than DEBOUNCE_CYCLES synchronized samples produces no output change.
- Reset mid-operation: the block returns to IDLE immediately. If the key is still held when `rs` falls, a full fresh debounce runs and one `tick` is emitted.
- `rs` has priority over every other event in the same cycle.

## Configuration
- `KEY_REPEAT_EN` defined: in HELD, repeat counter `rcnt` counts from entry into HELD.
  - The first repeat `tick` fires REPEAT_DELAY cycles after the press tick.
  - Subsequent ticks fire every REPEAT_PERIOD cycles.
  - `rcnt` clears on leaving HELD and on reset.
  - A return from REL_WAIT to HELD restarts `rcnt` at 0, with delay semantics.
- `KEY_REPEAT_EN` undefined: exactly one `tick` per accepted press. No repeat counter and its parameters are unused.

## Structure
- Shared package `key_pkg`:
  - state typedef `key_state_t` (IDLE, PRESS_WAIT, HELD, REL_WAIT);
  - localparam defaults for 50 MHz: `KEY_DEBOUNCE_20MS`, `KEY_REPEAT_DELAY_500MS`, `KEY_REPEAT_PERIOD_100MS`.
- One sub-module, `key_sync`: a 2-FF synchronizer with the same `ck`/`rs` ports and reset-to-1 behaviour. It is reused for SW inputs elsewhere.
- FSM, counters and output registers live in `key_debounce`.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3.
- **Clean press:**
  - Stimulus: `key_n` driven 1→0 and held 20 cycles.
  - Required: exactly one `tick`, high in the cycle after edge 6; `level`=1 from the same cycle.
- **Press bounce:**
  - Stimulus: `key_n` low 2 cycles, high 1 cycle, low 2 cycles, high.
  - Required: no `tick`; `level` stays 0.
- **Release bounce:**
  - Stimulus: from HELD, `key_n` high 2 cycles, low 1 cycle, then high.
  - Required: no extra `tick`; `level`=0 only after 4 stable released samples.
- **Reset mid-hold:**
  - Stimulus: `rs`=1 for 1 cycle while HELD and the key is still held.
  - Required: next cycle `level`=0, `tick`=0; one new `tick` follows 6 edges after `rs` falls.
- **Auto-repeat (`KEY_REPEAT_EN`):**
  - Stimulus: hold the key 30 cycles.
  - Required: press tick at T, repeats at T+8, T+11, T+14, …
  - Without the macro, the same stimulus gives a single tick.
- **Back-to-back presses:**
  - Stimulus: 5 clean press/release pairs, each phase 10 cycles.
  - Required: exactly 5 `tick` pulses.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and 50 MHz timing defaults for the KEY debounce path.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    HELD       = 2'd2,
    REL_WAIT   = 2'd3
  } key_state_t;

  localparam int KEY_DEBOUNCE_20MS       = 1000000;
  localparam int KEY_REPEAT_DELAY_500MS  = 25000000;
  localparam int KEY_REPEAT_PERIOD_100MS = 5000000;

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer for a raw asynchronous input; both flops reset to 1
// so an active-low button reads as released out of reset.
module key_sync (
  input  logic ck,
  input  logic rs,
  input  logic d,
  output logic q
);

  logic ff1;
  logic ff2;

  always_ff @(posedge ck) begin
    if (rs) begin
      ff1 <= 1'b1;
      ff2 <= 1'b1;
    end else begin
      ff1 <= d;
      ff2 <= ff1;
    end
  end

  assign q = ff2;

endmodule

// File: rtl/key_debounce.sv
// Debounces one active-low KEY into a clean level plus a one-cycle press tick.
// Define KEY_REPEAT_EN to add auto-repeat ticks while the key stays held.
module key_debounce
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_20MS,
  parameter int REPEAT_DELAY    = KEY_REPEAT_DELAY_500MS,
  parameter int REPEAT_PERIOD   = KEY_REPEAT_PERIOD_100MS
) (
  input  logic ck,
  input  logic rs,
  input  logic key_n,
  output logic level,
  output logic tick
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_param
    $error("key_debounce: cycle parameters must be >= 2");
  end

  logic          key_q;
  logic          s;
  key_state_t    state;
  logic [CW-1:0] cnt;
  logic          rep_hit;

  key_sync u_sync (
    .ck (ck),
    .rs (rs),
    .d  (key_n),
    .q  (key_q)
  );

  assign s = ~key_q;

`ifdef KEY_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rcnt;
  logic          rep;

  // rcnt runs only while steadily HELD; rep selects delay vs. period spacing.
  assign rep_hit = (state == HELD) && s && (rcnt == (rep ? RP_LAST : RD_LAST));

  always_ff @(posedge ck) begin
    if (rs || state != HELD || !s) begin
      rcnt <= '0;
      rep  <= 1'b0;
    end else if (rep_hit) begin
      rcnt <= '0;
      rep  <= 1'b1;
    end else begin
      rcnt <= rcnt + RW'(1);
    end
  end
`else
  assign rep_hit = 1'b0;
`endif

  always_ff @(posedge ck) begin
    if (rs) begin
      state <= IDLE;
      cnt   <= '0;
      level <= 1'b0;
      tick  <= 1'b0;
    end else begin
      tick <= 1'b0;
      case (state)
        IDLE: begin
          if (s) begin
            state <= PRESS_WAIT;
            cnt   <= CW'(1);
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            state <= HELD;
            level <= 1'b1;
            tick  <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HELD: begin
          if (!s) begin
            state <= REL_WAIT;
            cnt   <= CW'(1);
          end else if (rep_hit) begin
            tick <= 1'b1;
          end
        end
        REL_WAIT: begin
          // A return to pressed here is release bounce: back to HELD, no tick.
          if (s) begin
            state <= HELD;
          end else if (cnt == CNT_LAST) begin
            state <= IDLE;
            level <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3.
module tb_key_debounce;

  localparam int DC = 4;
  localparam int RD = 8;
  localparam int RP = 3;

  logic ck    = 1'b0;
  logic rs    = 1'b1;
  logic key_n = 1'b1;
  logic level;
  logic tick;

  int errs   = 0;
  int checks = 0;
  int tcnt;
  int total;
  logic [63:0] tmask;
  logic [63:0] exp_mask;

  key_debounce #(
    .DEBOUNCE_CYCLES (DC),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .ck    (ck),
    .rs    (rs),
    .key_n (key_n),
    .level (level),
    .tick  (tick)
  );

  always #5 ck = ~ck;

  // Advance n edges, sampling 1 time unit after each; bit e of tmask marks a tick after edge e.
  task automatic run(input int n);
    tmask = '0;
    tcnt  = 0;
    for (int e = 1; e <= n; e++) begin
      @(posedge ck);
      #1;
      if (tick === 1'b1) begin
        tcnt++;
        if (e < 64) tmask[e] = 1'b1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset
    run(3);
    chk("reset_level", 64'(level), 64'd0);
    chk("reset_tick", 64'(tick), 64'd0);
    rs = 1'b0;
    run(5);
    chk("idle_no_tick", 64'(tcnt), 64'd0);

    // clean press: tick and level after edge 6
    key_n = 1'b0;
    run(5);
    chk("press_early_tick", tmask, 64'd0);
    chk("press_early_level", 64'(level), 64'd0);
    run(1);
    chk("press_tick", 64'(tick), 64'd1);
    chk("press_level", 64'(level), 64'd1);
    run(14);
`ifdef KEY_REPEAT_EN
    exp_mask = (64'd1 << 8) | (64'd1 << 11) | (64'd1 << 14);
`else
    exp_mask = 64'd0;
`endif
    chk("press_hold_ticks", tmask, exp_mask);
    chk("press_hold_level", 64'(level), 64'd1);

    // clean release
    key_n = 1'b1;
    run(5);
    chk("release_early_level", 64'(level), 64'd1);
    chk("release_no_tick", tmask, 64'd0);
    run(1);
    chk("release_level", 64'(level), 64'd0);
    run(6);

    // press bounce: 2 low, 1 high, 2 low, high
    total = 0;
    key_n = 1'b0; run(2); total += tcnt;
    key_n = 1'b1; run(1); total += tcnt;
    key_n = 1'b0; run(2); total += tcnt;
    key_n = 1'b1; run(10); total += tcnt;
    chk("bounce_ticks", 64'(total), 64'd0);
    chk("bounce_level", 64'(level), 64'd0);

    // release bounce from HELD
    key_n = 1'b0;
    run(8);
    chk("rb_press_ticks", 64'(tcnt), 64'd1);
    chk("rb_press_level", 64'(level), 64'd1);
    total = 0;
    key_n = 1'b1; run(2); total += tcnt;
    key_n = 1'b0; run(1); total += tcnt;
    key_n = 1'b1; run(5); total += tcnt;
    chk("rb_level_held", 64'(level), 64'd1);
    run(1); total += tcnt;
    chk("rb_level_released", 64'(level), 64'd0);
    chk("rb_no_tick", 64'(total), 64'd0);
    run(6);

    // reset mid-hold
    key_n = 1'b0;
    run(8);
    chk("rh_level_before", 64'(level), 64'd1);
    rs = 1'b1;
    run(1);
    chk("rh_level_reset", 64'(level), 64'd0);
    chk("rh_tick_reset", 64'(tick), 64'd0);
    rs = 1'b0;
    run(5);
    chk("rh_early_tick", tmask, 64'd0);
    chk("rh_early_level", 64'(level), 64'd0);
    run(1);
    chk("rh_tick", 64'(tick), 64'd1);
    chk("rh_level", 64'(level), 64'd1);
    key_n = 1'b1;
    run(12);
    chk("rh_released", 64'(level), 64'd0);

    // long hold: auto-repeat when enabled, single tick otherwise
    key_n = 1'b0;
    run(30);
`ifdef KEY_REPEAT_EN
    exp_mask = (64'd1 << 6) | (64'd1 << 14) | (64'd1 << 17) | (64'd1 << 20)
             | (64'd1 << 23) | (64'd1 << 26) | (64'd1 << 29);
`else
    exp_mask = 64'd1 << 6;
`endif
    chk("hold30_ticks", tmask, exp_mask);
    key_n = 1'b1;
    run(12);
    chk("hold30_released", 64'(level), 64'd0);

    // back-to-back presses
    total = 0;
    for (int i = 0; i < 5; i++) begin
      key_n = 1'b0;
      run(10);
      total += tcnt;
      chk("b2b_level_press", 64'(level), 64'd1);
      key_n = 1'b1;
      run(10);
      total += tcnt;
      chk("b2b_level_release", 64'(level), 64'd0);
    end
    chk("b2b_ticks", 64'(total), 64'd5);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
